// File: rtl/lpc_pkg.sv
// Shared LPC definitions: cycle-type encodings, SYNC codes, response status and host FSM states.
package lpc_pkg;

  localparam logic [3:0] CT_IO_READ   = 4'b0000;
  localparam logic [3:0] CT_IO_WRITE  = 4'b0010;
  localparam logic [3:0] CT_MEM_READ  = 4'b0100;
  localparam logic [3:0] CT_MEM_WRITE = 4'b0110;

  localparam logic [1:0] TYPE_IO  = 2'b00;
  localparam logic [1:0] TYPE_MEM = 2'b01;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SHORT = 4'b0101;
  localparam logic [3:0] SYNC_LONG  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR = 4'b1010;

  localparam logic [1:0] RSP_OK       = 2'b00;
  localparam logic [1:0] RSP_SYNC_ERR = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT  = 2'b10;
  localparam logic [1:0] RSP_REJECT   = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CYCTYPE,
    ST_ADDR,
    ST_WDATA,
    ST_TAR_H,
    ST_TAR_Z,
    ST_SYNC,
    ST_RDATA,
    ST_PTAR_H,
    ST_PTAR_Z,
    ST_ABORT,
    ST_RESP
  } host_state_e;

endpackage

// File: rtl/lpc_nibble_shift.sv
// Nibble serializer: presents the top nibble of a loaded word and counts down the nibbles left.
module lpc_nibble_shift #(
  parameter int unsigned W = 24
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         count_load,
  input  logic [3:0]   count_value,
  input  logic         shift,
  output logic [3:0]   nibble,
  output logic         done
);

  logic [W-1:0] sr;
  logic [3:0]   count;

  always_ff @(posedge clock) begin
    if (reset) begin
      sr    <= '0;
      count <= '0;
      done  <= 1'b1;
    end else begin
      if (load)
        sr <= load_value;
      else if (shift)
        sr <= {sr[W-5:0], 4'h0};

      // A count reload wins over the decrement so a new phase can start on the same edge
      if (count_load) begin
        count <= count_value;
        done  <= (count_value == 4'd0);
      end else if (shift && (count != 4'd0)) begin
        count <= count - 4'd1;
        done  <= (count == 4'd1);
      end
    end
  end

  assign nibble = sr[W-1 -: 4];

endmodule

// File: rtl/lpc_host.sv
// LPC bus initiator: runs one I/O (or memory) cycle per command and reports data/status.
// Memory cycles are only supported when LPC_HOST_MEM_CYCLE_EN is defined.
module lpc_host
  import lpc_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned ABORT_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_cyctype_dir,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_status,
  output logic        lpc_frame,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in
);

`ifdef LPC_HOST_MEM_CYCLE_EN
  localparam int unsigned ADDR_W = 32;
`else
  localparam int unsigned ADDR_W = 16;
`endif
  localparam int unsigned SH_W  = ADDR_W + 8;
  localparam int unsigned CNT_W = 5;

  host_state_e      st;
  logic [1:0]       cyc_type;
  logic             cyc_dir;
  logic             sync_err;
  logic             rd_hi;
  logic [7:0]       rdata;
  logic [CNT_W-1:0] cnt;

  logic             accept_c;
  logic             type_ok_c;
  logic [SH_W-1:0]  sh_value_c;
  logic [3:0]       sh_count_value_c;
  logic             sh_count_load_c;
  logic             sh_shift_c;
  logic [3:0]       sh_nibble;
  logic             sh_done;

  assign accept_c = (st == ST_IDLE) && cmd_valid;

  // Shift stream is address MSB-first followed by data low then high nibble
`ifdef LPC_HOST_MEM_CYCLE_EN
  logic is_mem_c;
  logic unused_bits;
  assign is_mem_c         = (cmd_cyctype_dir[3:2] == TYPE_MEM);
  assign type_ok_c        = (cmd_cyctype_dir[3:2] == TYPE_IO) || is_mem_c;
  assign sh_value_c       = is_mem_c ? {cmd_addr, cmd_data[3:0], cmd_data[7:4]}
                                     : {cmd_addr[15:0], cmd_data[3:0], cmd_data[7:4], 16'h0000};
  assign sh_count_value_c = accept_c ? (is_mem_c ? 4'd8 : 4'd4) : 4'd1;
  assign unused_bits      = cmd_cyctype_dir[0];
`else
  logic unused_bits;
  assign type_ok_c        = (cmd_cyctype_dir[3:2] == TYPE_IO);
  assign sh_value_c       = {cmd_addr[15:0], cmd_data[3:0], cmd_data[7:4]};
  assign sh_count_value_c = accept_c ? 4'd4 : 4'd1;
  assign unused_bits      = ^{cmd_cyctype_dir[0], cmd_addr[31:16]};
`endif

  assign sh_count_load_c = accept_c || ((st == ST_ADDR) && sh_done && cyc_dir);
  assign sh_shift_c      = (st == ST_CYCTYPE)
                        || ((st == ST_ADDR) && (!sh_done || cyc_dir))
                        || ((st == ST_WDATA) && !sh_done);

  lpc_nibble_shift #(.W(SH_W)) u_shift (
    .clock       (clock),
    .reset       (reset),
    .load        (accept_c),
    .load_value  (sh_value_c),
    .count_load  (sh_count_load_c),
    .count_value (sh_count_value_c),
    .shift       (sh_shift_c),
    .nibble      (sh_nibble),
    .done        (sh_done)
  );

  // Bus outputs are registered together with the state they belong to
  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= ST_IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_status <= RSP_OK;
      lpc_frame  <= 1'b1;
      lpc_ad_out <= 4'hF;
      lpc_ad_oe  <= 1'b0;
      cyc_type   <= TYPE_IO;
      cyc_dir    <= 1'b0;
      sync_err   <= 1'b0;
      rd_hi      <= 1'b0;
      rdata      <= 8'h00;
      cnt        <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            cyc_type  <= cmd_cyctype_dir[3:2];
            cyc_dir   <= cmd_cyctype_dir[1];
            sync_err  <= 1'b0;
            if (type_ok_c) begin
              st         <= ST_START;
              lpc_frame  <= 1'b0;
              lpc_ad_out <= 4'h0;
              lpc_ad_oe  <= 1'b1;
            end else begin
              st         <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_data   <= 8'h00;
              rsp_status <= RSP_REJECT;
            end
          end
        end
        ST_START: begin
          st         <= ST_CYCTYPE;
          lpc_frame  <= 1'b1;
          lpc_ad_out <= {cyc_type, cyc_dir, 1'b0};
        end
        ST_CYCTYPE: begin
          st         <= ST_ADDR;
          lpc_ad_out <= sh_nibble;
        end
        ST_ADDR: begin
          if (!sh_done) begin
            lpc_ad_out <= sh_nibble;
          end else if (cyc_dir) begin
            st         <= ST_WDATA;
            lpc_ad_out <= sh_nibble;
          end else begin
            st         <= ST_TAR_H;
            lpc_ad_out <= 4'hF;
          end
        end
        ST_WDATA: begin
          if (!sh_done) begin
            lpc_ad_out <= sh_nibble;
          end else begin
            st         <= ST_TAR_H;
            lpc_ad_out <= 4'hF;
          end
        end
        ST_TAR_H: begin
          st        <= ST_TAR_Z;
          lpc_ad_oe <= 1'b0;
        end
        ST_TAR_Z: begin
          st  <= ST_SYNC;
          cnt <= '0;
        end
        ST_SYNC: begin
          if ((lpc_ad_in == SYNC_READY) || (lpc_ad_in == SYNC_ERROR)) begin
            sync_err <= (lpc_ad_in == SYNC_ERROR);
            rd_hi    <= 1'b0;
            st       <= cyc_dir ? ST_PTAR_H : ST_RDATA;
          end else if (cnt == CNT_W'(SYNC_TIMEOUT - 1)) begin
            st         <= ST_ABORT;
            cnt        <= '0;
            lpc_frame  <= 1'b0;
            lpc_ad_out <= 4'hF;
            lpc_ad_oe  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RDATA: begin
          if (!rd_hi) begin
            rdata[3:0] <= lpc_ad_in;
            rd_hi      <= 1'b1;
          end else begin
            rdata[7:4] <= lpc_ad_in;
            st         <= ST_PTAR_H;
          end
        end
        ST_PTAR_H: st <= ST_PTAR_Z;
        ST_PTAR_Z: begin
          st         <= ST_RESP;
          rsp_valid  <= 1'b1;
          rsp_data   <= cyc_dir ? 8'h00 : rdata;
          rsp_status <= sync_err ? RSP_SYNC_ERR : RSP_OK;
        end
        ST_ABORT: begin
          // LFRAME# low for ABORT_CYCLES, then one released idle cycle before RESP
          if (cnt == CNT_W'(ABORT_CYCLES)) begin
            st         <= ST_RESP;
            rsp_valid  <= 1'b1;
            rsp_data   <= 8'h00;
            rsp_status <= RSP_TIMEOUT;
          end else begin
            if (cnt == CNT_W'(ABORT_CYCLES - 1)) begin
              lpc_frame <= 1'b1;
              lpc_ad_oe <= 1'b0;
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          st        <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          st        <= ST_IDLE;
          cmd_ready <= 1'b1;
          lpc_frame <= 1'b1;
          lpc_ad_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: per-cycle bus vectors with hand-derived expectations.
module tb_lpc_host;
  import lpc_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_cyctype_dir;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_status;
  logic        lpc_frame;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in;

  lpc_host dut (
    .clock           (clock),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_cyctype_dir (cmd_cyctype_dir),
    .cmd_addr        (cmd_addr),
    .cmd_data        (cmd_data),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_status      (rsp_status),
    .lpc_frame       (lpc_frame),
    .lpc_ad_out      (lpc_ad_out),
    .lpc_ad_oe       (lpc_ad_oe),
    .lpc_ad_in       (lpc_ad_in)
  );

  always #5 clock = ~clock;

  // One record per bus cycle after accept: peripheral drive and expected host outputs
  typedef struct {
    logic [3:0] ai;
    logic       f;
    logic       o;
    logic [3:0] a;
    logic       rv;
  } vec_t;

  vec_t       vq[$];
  logic [3:0] bus_nib[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tname, input string sig, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s cycle %0d: got %0h, want %0h", tname, sig, k, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] ai, input logic f, input logic o,
                     input logic [3:0] a, input logic rv);
    vec_t v;
    v.ai = ai; v.f = f; v.o = o; v.a = a; v.rv = rv;
    vq.push_back(v);
  endtask

  // Zero-wait I/O write: START, CYCTYPE, 4 address, 2 data, TAR, SYNC, PTAR, RESP
  task automatic build_io_write(input logic [15:0] addr, input logic [7:0] data);
    add(4'hF, 1'b0, 1'b1, 4'h0, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h2, 1'b0);
    add(4'hF, 1'b1, 1'b1, addr[15:12], 1'b0);
    add(4'hF, 1'b1, 1'b1, addr[11:8], 1'b0);
    add(4'hF, 1'b1, 1'b1, addr[7:4], 1'b0);
    add(4'hF, 1'b1, 1'b1, addr[3:0], 1'b0);
    add(4'hF, 1'b1, 1'b1, data[3:0], 1'b0);
    add(4'hF, 1'b1, 1'b1, data[7:4], 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    add(SYNC_READY, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b1);
  endtask

  task automatic run_cmd(input string tname, input logic [3:0] ctd, input logic [31:0] addr,
                         input logic [7:0] data, input logic [7:0] exp_data,
                         input logic [1:0] exp_status);
    @(negedge clock);
    check(tname, "cmd_ready_pre", 0, 32'(cmd_ready), 32'd1);
    cmd_valid       = 1'b1;
    cmd_cyctype_dir = ctd;
    cmd_addr        = addr;
    cmd_data        = data;
    bus_nib.delete();
    for (int k = 1; k <= vq.size(); k++) begin
      @(negedge clock);
      if (k == 1) begin
        cmd_valid       = 1'b0;
        cmd_cyctype_dir = 4'($urandom);
        cmd_addr        = $urandom;
        cmd_data        = 8'($urandom);
      end
      check(tname, "lpc_frame", k, 32'(lpc_frame), 32'(vq[k-1].f));
      check(tname, "lpc_ad_oe", k, 32'(lpc_ad_oe), 32'(vq[k-1].o));
      check(tname, "rsp_valid", k, 32'(rsp_valid), 32'(vq[k-1].rv));
      check(tname, "cmd_ready", k, 32'(cmd_ready), 32'd0);
      if (vq[k-1].o) check(tname, "lpc_ad_out", k, 32'(lpc_ad_out), 32'(vq[k-1].a));
      if (vq[k-1].rv) begin
        check(tname, "rsp_data", k, 32'(rsp_data), 32'(exp_data));
        check(tname, "rsp_status", k, 32'(rsp_status), 32'(exp_status));
      end
      if (lpc_ad_oe) bus_nib.push_back(lpc_ad_out);
      lpc_ad_in = vq[k-1].ai;
    end
    @(negedge clock);
    check(tname, "cmd_ready_post", vq.size() + 1, 32'(cmd_ready), 32'd1);
    check(tname, "rsp_valid_post", vq.size() + 1, 32'(rsp_valid), 32'd0);
    lpc_ad_in = 4'hF;
    vq.delete();
  endtask

  logic [3:0] rej_types[4];

  initial begin
    reset           = 1'b1;
    cmd_valid       = 1'b0;
    cmd_cyctype_dir = 4'h0;
    cmd_addr        = 32'h0;
    cmd_data        = 8'h00;
    lpc_ad_in       = 4'hF;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset", "cmd_ready", 0, 32'(cmd_ready), 32'd1);
    check("reset", "rsp_valid", 0, 32'(rsp_valid), 32'd0);
    check("reset", "rsp_data", 0, 32'(rsp_data), 32'd0);
    check("reset", "rsp_status", 0, 32'(rsp_status), 32'd0);
    check("reset", "lpc_frame", 0, 32'(lpc_frame), 32'd1);
    check("reset", "lpc_ad_out", 0, 32'(lpc_ad_out), 32'hF);
    check("reset", "lpc_ad_oe", 0, 32'(lpc_ad_oe), 32'd0);

    // I/O write 0x0080 <= 0x34, ready on first SYNC; response in cycle N+14
    build_io_write(16'h0080, 8'h34);
    run_cmd("io_wr", CT_IO_WRITE, 32'h0000_0080, 8'h34, 8'h00, RSP_OK);
    check("io_wr_dec", "cyctype", 1, 32'(bus_nib[1]), 32'(CT_IO_WRITE));
    check("io_wr_dec", "addr", 2, 32'({bus_nib[2], bus_nib[3], bus_nib[4], bus_nib[5]}), 32'h0080);
    check("io_wr_dec", "data", 6, 32'({bus_nib[7], bus_nib[6]}), 32'h34);

    // I/O read 0x03F9: three short waits, then 0xA5 (low nibble 5 first)
    add(4'hF, 1'b0, 1'b1, 4'h0, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h0, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h0, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h3, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h9, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    add(SYNC_SHORT, 1'b1, 1'b0, 4'hF, 1'b0);
    add(SYNC_SHORT, 1'b1, 1'b0, 4'hF, 1'b0);
    add(SYNC_SHORT, 1'b1, 1'b0, 4'hF, 1'b0);
    add(SYNC_READY, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'h5, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hA, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'h0, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'h6, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b1);
    run_cmd("io_rd", CT_IO_READ, 32'h0000_03F9, 8'h00, 8'hA5, RSP_OK);

    // I/O write 0x0CF8 with no peripheral: 8 wait cycles, 4 abort cycles, 1 idle, RESP
    add(4'hF, 1'b0, 1'b1, 4'h0, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h2, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h0, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'hC, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h8, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'hA, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h5, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    add(SYNC_LONG, 1'b1, 1'b0, 4'hF, 1'b0);
    add(SYNC_SHORT, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    add(SYNC_LONG, 1'b1, 1'b0, 4'hF, 1'b0);
    add(SYNC_SHORT, 1'b1, 1'b0, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) add(4'hF, 1'b0, 1'b1, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b1);
    run_cmd("timeout", CT_IO_WRITE, 32'h0000_0CF8, 8'h5A, 8'h00, RSP_TIMEOUT);

`ifdef LPC_HOST_MEM_CYCLE_EN
    // Memory read 0xFFFFFFF0 ending SYNC with error; data 0xC3 still returned
    add(4'hF, 1'b0, 1'b1, 4'h0, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h4, 1'b0);
    for (int i = 0; i < 7; i++) add(4'hF, 1'b1, 1'b1, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'h0, 1'b0);
    add(4'hF, 1'b1, 1'b1, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    add(SYNC_ERROR, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'h3, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hC, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b1);
    run_cmd("mem_rd", CT_MEM_READ, 32'hFFFF_FFF0, 8'h00, 8'hC3, RSP_SYNC_ERR);
    rej_types[0] = 4'b1000; rej_types[1] = 4'b1110;
    rej_types[2] = 4'b1010; rej_types[3] = 4'b1100;
`else
    // Memory read rejected: no START, RESP in cycle N+1 with status 11
    add(4'hF, 1'b1, 1'b0, 4'hF, 1'b1);
    run_cmd("mem_rd_rej", CT_MEM_READ, 32'hFFFF_FFF0, 8'h00, 8'h00, RSP_REJECT);
    rej_types[0] = 4'b1000; rej_types[1] = 4'b1110;
    rej_types[2] = CT_MEM_WRITE; rej_types[3] = 4'b1100;
`endif

    for (int i = 0; i < 4; i++) begin
      add(4'hF, 1'b1, 1'b0, 4'hF, 1'b1);
      run_cmd($sformatf("reject_%0h", rej_types[i]), rej_types[i], 32'h0000_1234, 8'h99,
              8'h00, RSP_REJECT);
    end

    // Reset asserted while address nibbles are on the bus
    @(negedge clock);
    cmd_valid = 1'b1; cmd_cyctype_dir = CT_IO_WRITE; cmd_addr = 32'h0000_0011; cmd_data = 8'h22;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_mid", "ad_before", 3, 32'(lpc_ad_out), 32'h0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid", "lpc_frame", 4, 32'(lpc_frame), 32'd1);
    check("rst_mid", "lpc_ad_oe", 4, 32'(lpc_ad_oe), 32'd0);
    check("rst_mid", "cmd_ready", 4, 32'(cmd_ready), 32'd1);
    check("rst_mid", "rsp_valid", 4, 32'(rsp_valid), 32'd0);
    for (int k = 5; k < 21; k++) begin
      @(negedge clock);
      check("rst_mid", "rsp_valid_quiet", k, 32'(rsp_valid), 32'd0);
      check("rst_mid", "frame_quiet", k, 32'(lpc_frame), 32'd1);
    end

    build_io_write(16'h002E, 8'hC1);
    run_cmd("io_wr_after_rst", CT_IO_WRITE, 32'h0000_002E, 8'hC1, 8'h00, RSP_OK);
    check("io_wr2_dec", "addr", 2, 32'({bus_nib[2], bus_nib[3], bus_nib[4], bus_nib[5]}), 32'h002E);
    check("io_wr2_dec", "data", 6, 32'({bus_nib[7], bus_nib[6]}), 32'hC1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lpc_host.md
# lpc_host

LPC bus initiator: takes one command (I/O or memory, read or write) at a time from an internal request port and drives the matching LPC cycle (START, CYCTYPE+DIR, ADDR, DATA, TAR, SYNC) onto LAD[3:0]/LFRAME#. It returns read data and a completion status on a response port. It is the transmit-side counterpart of the `lpc` decoder and uses the same 4-bit `cyctype_dir` encoding, so bench and firmware can replay captured sniffer records.

## Interface
- `SYNC_TIMEOUT`, 8: maximum consecutive SYNC cycles showing 1111/0101/0110 before abort.
- `ABORT_CYCLES`, 4: LFRAME# low cycles during abort.
- `clock` in 1: LPC clock; the whole block runs on it. One clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; transfer on `cmd_valid && cmd_ready`.
- `cmd_cyctype_dir` in 4: [3:2] type (00 I/O, 01 mem), [1] dir (1 = write), [0] ignored.
- `cmd_addr` in 32: I/O uses [15:0]; mem uses [31:0].
- `cmd_data` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse; no backpressure.
- `rsp_data` out 8: read data; 0 for writes.
- `rsp_status` out 2: 00 ok, 01 sync error (1010), 10 timeout, 11 rejected.
- `lpc_frame` out 1: LFRAME#, active-low.
- `lpc_ad_out` out 4: LAD drive value.
- `lpc_ad_oe` out 1: LAD output enable.
- `lpc_ad_in` in 4: sampled LAD.

## Operation
- Reset values: `cmd_ready`=1 after the first post-reset cycle, `rsp_valid`=0, `rsp_data`=0, `rsp_status`=00, `lpc_frame`=1, `lpc_ad_out`=1111, `lpc_ad_oe`=0.
- States: IDLE → START → CYCTYPE → ADDR → (write: WDATA) → TAR_H → TAR_Z → SYNC → (read: RDATA) → PTAR_H → PTAR_Z → RESP → IDLE; ABORT → RESP on timeout.
- START: `lpc_frame`=0, AD=0000, oe=1. CYCTYPE: AD={type,dir,0}.
- ADDR: I/O 4 nibbles, mem 8 nibbles, MSB first. WDATA: 2 nibbles, low nibble first.
- TAR_H: AD=1111, oe=1. TAR_Z: oe=0. The host stays released from TAR_Z until RESP.
- SYNC: 0000 ends SYNC ok; 1010 ends SYNC with error and the sequence continues normally; 0101/0110/1111 wait and increment the timeout counter.
- When the counter reaches `SYNC_TIMEOUT`: enter ABORT (`lpc_frame`=0, AD=1111, oe=1 for `ABORT_CYCLES`), then one idle cycle, then RESP with status 10.
- RDATA: capture low nibble, then high nibble.
- PTAR_H/PTAR_Z: the peripheral turnaround. `lpc_ad_in` is ignored.
- RESP: `rsp_valid`=1 for one cycle with `rsp_data`/`rsp_status`; outputs hold until the next RESP.
- Commands with type 10/11 are rejected: no bus activity, RESP the cycle after accept, status 11.
- `cmd_*` is registered at accept; later changes are ignored.
- Reset mid-cycle: next cycle is IDLE, `lpc_frame`=1, oe=0; no `rsp_valid` for the interrupted command.

## Timing
- Accept at edge N; START occupies cycle N+1.
- Zero-wait I/O read or write: 13 bus cycles, `rsp_valid` in cycle N+14. Memory: `rsp_valid` in cycle N+18.
- Each SYNC wait cycle adds 1.
- Timeout path: START..TAR (write 10, read 8 cycles), + `SYNC_TIMEOUT` + `ABORT_CYCLES` + 1 idle, then RESP.
- `cmd_ready` drops the cycle after accept and returns the cycle after RESP. Back-to-back commands therefore have one idle bus cycle between them.

## Configuration
- `LPC_HOST_MEM_CYCLE_EN` defined: memory cycles (type 01, 8 address nibbles) supported.
- Not defined: type 01 is rejected like 10/11 (status 11, no bus activity), and the address shifter is 16 bits.

## Structure
- Shared package `lpc_pkg`:
  - cyctype/dir constants (IO_READ 0000, IO_WRITE 0010, MEM_READ 0100, MEM_WRITE 0110)
  - SYNC codes (READY 0000, SHORT 0101, LONG 0110, ERROR 1010)
  - `rsp_status` codes
  - host state enum
- Sub-module `lpc_nibble_shift`: loads address/data and presents one nibble per cycle (MSB-first for address, LSB-first for data) with a nibble-count done flag. The FSM and timeout counter stay in `lpc_host`.

## Test plan
- I/O write, addr 0x0080, data 0x34, SYNC 0000 on first cycle.
  - AD sequence 0000,0010,0,0,8,0,4,3,F,Z; `rsp_valid` at N+14, status 00.
  - The `lpc` decoder model reports cyctype 0010, addr 0x80, data 0x34.
- I/O read, addr 0x03F9, peripheral SYNC 0101×3 then 0000, data 0xA5 (nibbles 5,A).
  - `rsp_data`=0xA5, status 00, `rsp_valid` at N+17.
- Peripheral never drives (AD=1111).
  - After 8 SYNC cycles: `lpc_frame` low 4 cycles with AD=1111, then `rsp_valid` with status 10.
- Mem read, addr 0xFFFFFFF0, SYNC 1010.
  - With macro: 8 address nibbles, status 01.
  - Without macro: no `lpc_frame` edge, status 11 at N+1.
- Reset asserted during ADDR.
  - Next cycle `lpc_frame`=1, oe=0, `cmd_ready`=1; no `rsp_valid`.
  - A following I/O write completes normally.
